hash_freq_engine: RTL and testbench
===================================

Name: hash_freq_engine

Overview:
- Parametrised successor to the single-channel normal-hash builder.
- Consumes a stream of keys and builds a key/occurrence-count table inside the block. The table uses open addressing with linear probing.
- Adds behaviour the previous builder lacks:
  - valid/ready input handshake;
  - generic key, count and table widths;
  - bounded probing with a drop counter;
  - count saturation;
  - table clear sweep;
  - pause/resume with preserved context;
  - host read-back port.
- Sits between the data cache front-end and the AXI register/readout logic of the DataFreqExt IP core.

Parameters:
- KEY_WIDTH, 32, width of each key and of stored keys.
- COUNT_WIDTH, 16, width of the per-entry occurrence count. Saturates at all-ones.
- ADDR_BITS, 7, table address width. TABLE_DEPTH = 2**ADDR_BITS.
- LEN_WIDTH, 16, width of the run-length and processed counters.
- PROBE_LIMIT, 128, maximum slots examined per key. Legal range 1..TABLE_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse. Begins a run. Ignored unless in IDLE or DONE.
- clear  in  1  sampled with start. 1 = zero the whole table before accepting keys.
- cfg_length  in  LEN_WIDTH  number of keys in the run. 0 = finish immediately.
- pause  in  1  level. Honoured only in ACCEPT.
- resume  in  1  pulse. Leaves PAUSED.
- in_valid  in  1  key valid.
- in_key  in  KEY_WIDTH  key.
- in_ready  out  1  high only in ACCEPT.
- busy  out  1  high in every state except IDLE, PAUSED and DONE.
- paused  out  1  state == PAUSED.
- done  out  1  one-cycle pulse on entry to DONE.
- processed  out  LEN_WIDTH  keys accepted this run.
- collisions  out  32  total extra probes this run.
- dropped  out  LEN_WIDTH  keys discarded because PROBE_LIMIT was reached.
- saturated  out  1  sticky per run. A count hit all-ones.
- occupancy  out  ADDR_BITS+1  number of non-empty slots.
- rd_en  in  1  host read request. Ignored while busy.
- rd_addr  in  ADDR_BITS  slot to read.
- rd_valid  out  1  pulse, one cycle after an accepted rd_en.
- rd_key  out  KEY_WIDTH  stored key.
- rd_count  out  COUNT_WIDTH  stored count. 0 = empty slot.

Behaviour:
- Reset:
  - state IDLE;
  - all outputs 0;
  - all counters 0;
  - table contents undefined. The first run must use clear=1.
- Reset mid-run aborts immediately and returns to IDLE. The table is left undefined.
- Table memory: one port, synchronous read with 1-cycle latency, write on the same port. Each entry = {key, count}.
- Home slot = in_key[ADDR_BITS-1:0]. Probe sequence = home, home+1, ... modulo TABLE_DEPTH (wraps TABLE_DEPTH-1 → 0).
- State IDLE/DONE + start:
  - clears processed, collisions, dropped and saturated;
  - clear=1 → CLEAR, otherwise ACCEPT.
  - If cfg_length == 0: go to DONE with done pulse.
- CLEAR: writes one slot per cycle, address 0..TABLE_DEPTH-1. Lasts TABLE_DEPTH cycles, then occupancy=0 and go to ACCEPT.
- ACCEPT:
  - If pause=1: go to PAUSED. in_ready=0 in that cycle.
  - Else if in_valid: latch the key, processed++, probe_cnt=0, go to READ.
- READ: drives the slot address. Next state COMPARE.
- COMPARE (uses the read data):
  - Hit (count≠0 and key equal) or empty (count==0): go to WRITE.
  - Miss, probe_cnt+1 < PROBE_LIMIT: collisions++, address+1 (wraps), go to READ.
  - Miss, probe_cnt+1 == PROBE_LIMIT: dropped++, go to NEXT. No write.
- WRITE:
  - Stores the key and count+1.
  - If the count is already all-ones: keep it and set saturated.
  - If the slot was empty: occupancy++.
  - Go to NEXT.
- NEXT: if processed == cfg_length, go to DONE with done pulse. Else go to ACCEPT.
- Latency: a key with no collision takes 5 cycles from handshake to the next in_ready (ACCEPT, READ, COMPARE, WRITE, NEXT). Each extra probe adds 2 cycles.
- PAUSED:
  - all context kept (counters, table, run position);
  - resume → ACCEPT;
  - start is ignored while PAUSED.
- Simultaneous pause and in_valid in ACCEPT: pause wins and the key is not taken.
- Host reads:
  - accepted in IDLE, PAUSED and DONE;
  - rd_valid, rd_key and rd_count arrive 1 cycle after rd_en;
  - rd_en while busy returns nothing.

Decomposition:
- Package hash_freq_pkg holds:
  - state enum (IDLE, CLEAR, ACCEPT, READ, COMPARE, WRITE, NEXT, PAUSED, DONE);
  - clog2 function;
  - entry-width constants.
- One natural sub-module: hash_table_ram, a single-port synchronous RAM of TABLE_DEPTH x (KEY_WIDTH+COUNT_WIDTH). It is internally muxed between the engine and host reads.

Test Plan:
- start clear=1, cfg_length=3, keys 5,5,5 → slot 5 = {5,3}; occupancy=1; collisions=0; processed=3; a single done pulse.
- ADDR_BITS=7, keys 1,129,257 → slots 1,2,3; collisions=3; occupancy=3.
- Keys 127 then 255 → 255 wraps into slot 0; collisions=1.
- PROBE_LIMIT=4, keys 10,138,266,394 fill slots 10..13, then key 522 → dropped=1; occupancy stays 4; slot 14 read back with count 0.
- cfg_length=5, pause held after 2 keys → paused=1, in_ready=0, processed=2. Pulse resume → the remaining 3 keys are accepted; processed=5; done pulses.
- COUNT_WIDTH=2, key 7 sent 5 times → rd_count=3; saturated=1. Separately, rst asserted mid-run → IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/hash_freq_pkg.sv
// Shared types and helpers for the hash frequency engine.
// State encoding, width helpers and entry layout constants.
package hash_freq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    ACCEPT,
    READ,
    COMPARE,
    WRITE,
    NEXT,
    PAUSED,
    DONE
  } state_e;

  localparam int DEF_KEY_W = 32;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ENTRY_W = DEF_KEY_W + DEF_CNT_W;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int entry_w(input int kw, input int cw);
    return kw + cw;
  endfunction

endpackage

// File: rtl/hash_freq_engine_if.sv
// Key stream handshake bundle between a key source and the engine.
// The source drives valid/key, the engine answers with ready.
interface hash_freq_engine_if #(
  parameter int KEY_WIDTH = 32
);
  logic                 in_valid;
  logic [KEY_WIDTH-1:0] in_key;
  logic                 in_ready;

  modport master (
    output in_valid,
    output in_key,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_key,
    output in_ready
  );
endinterface

// File: rtl/hash_table_ram.sv
// Single-port table RAM, synchronous read with one cycle latency.
// Read data holds its value until the next read access.
module hash_table_ram #(
  parameter int AW = 7,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hash_freq_engine.sv
// Key occurrence counter over an open-addressed, linearly probed table.
// Host reads share the single RAM port while the engine is not busy.
module hash_freq_engine
  import hash_freq_pkg::*;
#(
  parameter int KEY_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int ADDR_BITS   = 7,
  parameter int LEN_WIDTH   = 16,
  parameter int PROBE_LIMIT = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic [LEN_WIDTH-1:0]   cfg_length,
  input  logic                   pause,
  input  logic                   resume,
  hash_freq_engine_if.slave      kin,
  output logic                   busy,
  output logic                   paused,
  output logic                   done,
  output logic [LEN_WIDTH-1:0]   processed,
  output logic [31:0]            collisions,
  output logic [LEN_WIDTH-1:0]   dropped,
  output logic                   saturated,
  output logic [ADDR_BITS:0]     occupancy,
  input  logic                   rd_en,
  input  logic [ADDR_BITS-1:0]   rd_addr,
  output logic                   rd_valid,
  output logic [KEY_WIDTH-1:0]   rd_key,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  localparam int EW = entry_w(KEY_WIDTH, COUNT_WIDTH);
  localparam int PW = clog2(PROBE_LIMIT + 1);
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  state_e               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [PW-1:0]        pcnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] proc_q;
  logic [31:0]          coll_q;
  logic [LEN_WIDTH-1:0] drop_q;
  logic                 sat_q;
  logic [ADDR_BITS:0]   occ_q;
  logic                 done_q;
  logic                 rd_valid_q;

  logic                   ram_en;
  logic                   ram_we;
  logic [ADDR_BITS-1:0]   ram_addr;
  logic [EW-1:0]          ram_wdata;
  logic [EW-1:0]          ram_rdata;
  logic [KEY_WIDTH-1:0]   slot_key;
  logic [COUNT_WIDTH-1:0] slot_cnt;
  logic [COUNT_WIDTH-1:0] new_cnt;
  logic                   slot_empty;
  logic                   slot_hit;
  logic                   last_probe;
  logic                   host_rd;

  assign slot_key   = ram_rdata[EW-1 -: KEY_WIDTH];
  assign slot_cnt   = ram_rdata[COUNT_WIDTH-1:0];
  assign slot_empty = (slot_cnt == '0);
  assign slot_hit   = slot_empty | (slot_key == key_q);
  assign new_cnt    = (slot_cnt == CMAX) ? slot_cnt : slot_cnt + 1'b1;
  assign last_probe = (int'(pcnt_q) + 1 >= PROBE_LIMIT);

  assign busy   = state_q inside {CLEAR, ACCEPT, READ, COMPARE, WRITE, NEXT};
  assign paused = (state_q == PAUSED);
  assign host_rd = rd_en & ~busy;

  assign kin.in_ready = (state_q == ACCEPT) & ~pause;

  // Read data stays in the RAM output latch through WRITE
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = '0;
    unique case (1'b1)
      state_q == CLEAR: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      state_q == READ: ram_en = 1'b1;
      state_q == WRITE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = {key_q, new_cnt};
      end
      host_rd: begin
        ram_en   = 1'b1;
        ram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  hash_table_ram #(
    .AW (ADDR_BITS),
    .DW (EW)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      key_q      <= '0;
      pcnt_q     <= '0;
      len_q      <= '0;
      proc_q     <= '0;
      coll_q     <= '0;
      drop_q     <= '0;
      sat_q      <= 1'b0;
      occ_q      <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= host_rd;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            proc_q <= '0;
            coll_q <= '0;
            drop_q <= '0;
            sat_q  <= 1'b0;
            len_q  <= cfg_length;
            addr_q <= '0;
            if (cfg_length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (clear) begin
              state_q <= CLEAR;
            end else begin
              state_q <= ACCEPT;
            end
          end
        end
        CLEAR: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == '1) begin
            occ_q   <= '0;
            state_q <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (pause) begin
            state_q <= PAUSED;
          end else if (kin.in_valid) begin
            key_q   <= kin.in_key;
            addr_q  <= kin.in_key[ADDR_BITS-1:0];
            proc_q  <= proc_q + 1'b1;
            pcnt_q  <= '0;
            state_q <= READ;
          end
        end
        READ: state_q <= COMPARE;
        COMPARE: begin
          if (slot_hit) begin
            state_q <= WRITE;
          end else if (!last_probe) begin
            coll_q  <= coll_q + 1;
            addr_q  <= addr_q + 1'b1;
            pcnt_q  <= pcnt_q + 1'b1;
            state_q <= READ;
          end else begin
            drop_q  <= drop_q + 1'b1;
            state_q <= NEXT;
          end
        end
        WRITE: begin
          if (slot_cnt == CMAX) sat_q <= 1'b1;
          if (slot_empty) occ_q <= occ_q + 1'b1;
          state_q <= NEXT;
        end
        NEXT: begin
          if (proc_q == len_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ACCEPT;
          end
        end
        PAUSED: if (resume) state_q <= ACCEPT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign processed  = proc_q;
  assign collisions = coll_q;
  assign dropped    = drop_q;
  assign saturated  = sat_q;
  assign occupancy  = occ_q;
  assign rd_valid   = rd_valid_q;
  assign rd_key     = rd_valid_q ? slot_key : '0;
  assign rd_count   = rd_valid_q ? slot_cnt : '0;

endmodule

// File: tb/tb_hash_freq_engine.sv
// Bench for hash_freq_engine: directed cases plus a randomized run,
// compared against a plain array model of the probed table.
module tb_hash_freq_engine;

  localparam int KW = 32;
  localparam int CW = 2;
  localparam int AW = 7;
  localparam int LW = 16;
  localparam int PL = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CMAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic pause = 1'b0;
  logic resume = 1'b0;
  logic rd_en = 1'b0;
  logic [LW-1:0] cfg_length = '0;
  logic [AW-1:0] rd_addr = '0;

  logic          busy, paused, done, saturated, rd_valid;
  logic [LW-1:0] processed, dropped;
  logic [31:0]   collisions;
  logic [AW:0]   occupancy;
  logic [KW-1:0] rd_key;
  logic [CW-1:0] rd_count;

  hash_freq_engine_if #(.KEY_WIDTH(KW)) kif ();

  always #5 clk = ~clk;

  hash_freq_engine #(
    .KEY_WIDTH   (KW),
    .COUNT_WIDTH (CW),
    .ADDR_BITS   (AW),
    .LEN_WIDTH   (LW),
    .PROBE_LIMIT (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .cfg_length (cfg_length),
    .pause      (pause),
    .resume     (resume),
    .kin        (kif.slave),
    .busy       (busy),
    .paused     (paused),
    .done       (done),
    .processed  (processed),
    .collisions (collisions),
    .dropped    (dropped),
    .saturated  (saturated),
    .occupancy  (occupancy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_key     (rd_key),
    .rd_count   (rd_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [KW-1:0] m_key [DEPTH];
  int            m_cnt [DEPTH];
  int m_proc, m_coll, m_drop, m_occ, m_len;
  bit m_sat;

  task automatic check(input string name, input longint act,
                       input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_start(input bit c, input int len);
    m_proc = 0;
    m_coll = 0;
    m_drop = 0;
    m_sat  = 1'b0;
    m_len  = len;
    if (c) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_key[i] = '0;
        m_cnt[i] = 0;
      end
      m_occ = 0;
    end
  endtask

  // Returns the handshake-to-ready latency the key should take
  function automatic int model_accept(input logic [KW-1:0] k);
    int s;
    m_proc++;
    for (int p = 0; p < PL; p++) begin
      s = (int'(k % DEPTH) + p) % DEPTH;
      if (m_cnt[s] == 0 || m_key[s] == k) begin
        if (m_cnt[s] == 0) m_occ++;
        if (m_cnt[s] == CMAXV) m_sat = 1'b1;
        else m_cnt[s]++;
        m_key[s] = k;
        m_coll += p;
        return 5 + 2 * p;
      end
    end
    m_coll += PL - 1;
    m_drop++;
    return 2 + 2 * PL;
  endfunction

  always @(negedge clk) begin
    if (!rst && (kif.in_ready || done)) begin
      check("mon_processed", processed, m_proc);
      check("mon_collisions", collisions, m_coll);
      check("mon_dropped", dropped, m_drop);
      check("mon_saturated", saturated, m_sat);
      check("mon_occupancy", occupancy, m_occ);
    end
    if (done) done_cnt++;
  end

  task automatic run_start(input bit c, input int len);
    done_cnt = 0;
    start = 1'b1;
    clear = c;
    cfg_length = LW'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    model_start(c, len);
    @(negedge clk);
  endtask

  task automatic send_key(input logic [KW-1:0] k);
    int n, exp_lat;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (kif.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 0, 1);
      return;
    end
    kif.in_valid = 1'b1;
    kif.in_key = k;
    @(posedge clk);
    #1;
    kif.in_valid = 1'b0;
    exp_lat = model_accept(k);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (kif.in_ready || !busy) break;
      n++;
    end
    check("latency", n, exp_lat);
  endtask

  task automatic finish_run();
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy, 0);
  endtask

  task automatic rd_slot(input int a, output logic [KW-1:0] k,
                         output int c);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_valid", rd_valid, 1);
    check("rd_key_model", rd_key, m_key[a]);
    check("rd_count_model", rd_count, m_cnt[a]);
    k = rd_key;
    c = int'(rd_count);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, kif.in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_paused"}, paused, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_processed"}, processed, 0);
    check({tag, "_collisions"}, collisions, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_saturated"}, saturated, 0);
    check({tag, "_occupancy"}, occupancy, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_key"}, rd_key, 0);
    check({tag, "_rd_count"}, rd_count, 0);
  endtask

  initial begin
    logic [KW-1:0] k;
    logic [KW-1:0] rk;
    int rc, len;
    logic [KW-1:0] tkeys [5];

    kif.in_valid = 1'b0;
    kif.in_key = '0;
    model_start(1'b1, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Same key three times lands in its home slot
    run_start(1'b1, 3);
    repeat (3) send_key(32'd5);
    finish_run();
    rd_slot(5, rk, rc);
    check("t1_key", rk, 5);
    check("t1_count", rc, 3);
    check("t1_occ", occupancy, 1);
    check("t1_coll", collisions, 0);
    check("t1_proc", processed, 3);

    // Colliding homes spread to following slots
    run_start(1'b1, 3);
    send_key(32'd1);
    send_key(32'd129);
    send_key(32'd257);
    finish_run();
    check("t2_coll", collisions, 3);
    check("t2_occ", occupancy, 3);
    rd_slot(2, rk, rc);
    check("t2_slot2_key", rk, 129);
    rd_slot(3, rk, rc);
    check("t2_slot3_key", rk, 257);

    // Probe wraps from the last slot to slot 0
    run_start(1'b1, 2);
    send_key(32'd127);
    send_key(32'd255);
    finish_run();
    check("t3_coll", collisions, 1);
    rd_slot(0, rk, rc);
    check("t3_slot0_key", rk, 255);
    check("t3_slot0_cnt", rc, 1);

    // Probe limit reached drops the key
    tkeys = '{32'd10, 32'd138, 32'd266, 32'd394, 32'd522};
    run_start(1'b1, 5);
    foreach (tkeys[i]) send_key(tkeys[i]);
    finish_run();
    check("t4_dropped", dropped, 1);
    check("t4_occ", occupancy, 4);
    check("t4_coll", collisions, 9);
    rd_slot(14, rk, rc);
    check("t4_slot14_cnt", rc, 0);

    // Pause after two keys, start ignored, then resume
    run_start(1'b1, 5);
    send_key(32'd20);
    send_key(32'd21);
    pause = 1'b1;
    @(negedge clk);
    check("t5_paused", paused, 1);
    check("t5_in_ready", kif.in_ready, 0);
    check("t5_proc", processed, 2);
    start = 1'b1;
    cfg_length = '0;
    @(negedge clk);
    start = 1'b0;
    check("t5_start_ignored", paused, 1);
    check("t5_done_ignored", done_cnt, 0);
    rd_slot(21, rk, rc);
    check("t5_rd_paused", rc, 1);
    pause = 1'b0;
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    @(negedge clk);
    send_key(32'd22);
    send_key(32'd20);
    send_key(32'd300);
    finish_run();
    check("t5_proc_end", processed, 5);

    // Count saturates at all-ones
    run_start(1'b1, 5);
    repeat (5) send_key(32'd7);
    finish_run();
    check("t6_sat", saturated, 1);
    rd_slot(7, rk, rc);
    check("t6_count", rc, 3);

    // Zero-length run finishes at once
    run_start(1'b0, 0);
    finish_run();
    check("t7_proc", processed, 0);

    // Randomized runs with occasional pauses, then full read-back
    for (int r = 0; r < 2; r++) begin
      len = 40 + int'($urandom_range(0, 20));
      run_start(r == 0, len);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check("rd_while_busy", rd_valid, 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 0)
          k = ($urandom_range(0, 5) << 7) | $urandom_range(0, 3);
        else
          k = $urandom;
        send_key(k);
        if (i < len - 1 && $urandom_range(0, 7) == 0) begin
          pause = 1'b1;
          @(negedge clk);
          check("rand_paused", paused, 1);
          pause = 1'b0;
          resume = 1'b1;
          @(posedge clk);
          #1;
          resume = 1'b0;
          @(negedge clk);
        end
      end
      finish_run();
      for (int a = 0; a < DEPTH; a++) rd_slot(a, rk, rc);
    end

    // Reset in the middle of a key aborts the run
    run_start(1'b0, 5);
    kif.in_valid = 1'b1;
    kif.in_key = 32'd9;
    @(posedge clk);
    #1;
    kif.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst = 1'b0;
    model_start(1'b1, 0);
    @(negedge clk);
    check("post_reset_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
